w0rm_sync_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready synchronizer channel among `NUM_INPUTS` independent requesters. Each requester presents a valid/ready/data stream. The arbiter selects one per cycle and registers the winning word into a single output stage, which feeds the downstream `W0RM_Synchro` input. Grant order is fair rotation, with optional burst retention. Source identity travels alongside the data.

---
 rtl/w0rm_sync_arbiter.sv | 95 +++++++++
 tb/tb_w0rm_sync_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/w0rm_sync_arbiter.sv
// rtl/w0rm_sync_arbiter.sv - round-robin valid/ready arbiter feeding one registered output stage
// Burst retention is enabled by defining W0RM_SYNC_ARB_BURST_EN.
module w0rm_sync_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 4,
  parameter int BURST_LEN  = 4,
  localparam int SRC_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            input_valid,
  output logic [NUM_INPUTS-1:0]            input_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] input_data,
  output logic                             output_valid,
  input  logic                             output_ready,
  output logic [DATA_WIDTH-1:0]            output_data,
  output logic [SRC_WIDTH-1:0]             output_source
);

  if (NUM_INPUTS < 2 || NUM_INPUTS > 8 || BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_params
    $error("w0rm_sync_arbiter: NUM_INPUTS must be 2..8 and BURST_LEN 1..255");
  end

  logic [SRC_WIDTH-1:0]  last;
  logic [SRC_WIDTH-1:0]  win;
  logic                  free;
  logic                  take;
  logic                  hold;
  logic [DATA_WIDTH-1:0] words [NUM_INPUTS];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_words
    assign words[i] = input_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign free = ~output_valid | output_ready;
  assign take = free & ~reset & (|input_valid);

`ifdef W0RM_SYNC_ARB_BURST_EN
  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);
  logic [7:0] burst_cnt;

  // A zero count only exists straight after reset, where requester 0 must still win first.
  assign hold = (burst_cnt != 8'd0) && (burst_cnt < BURST_MAX) && input_valid[last];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= 8'd0;
    end else if (take) begin
      if (win == last) begin
        if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 8'd1;
      end else begin
        burst_cnt <= 8'd1;
      end
    end
  end
`else
  assign hold = 1'b0;
`endif

  // Descending scan so the lowest rotation offset with a valid request is the last write.
  always_comb begin : sel
    int                   start;
    logic [SRC_WIDTH-1:0] idx;
    start = int'(last);
    idx   = '0;
    win   = '0;
    if (!hold) start = (start == NUM_INPUTS-1) ? 0 : start + 1;
    for (int k = NUM_INPUTS-1; k >= 0; k--) begin
      idx = SRC_WIDTH'((start + k) % NUM_INPUTS);
      if (input_valid[idx]) win = idx;
    end
  end

  always_comb begin
    input_ready = '0;
    if (take) input_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      output_valid  <= 1'b0;
      output_data   <= '0;
      output_source <= '0;
      last          <= SRC_WIDTH'(NUM_INPUTS-1);
    end else if (take) begin
      output_valid  <= 1'b1;
      output_data   <= words[win];
      output_source <= win;
      last          <= win;
    end else if (output_ready) begin
      output_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_w0rm_sync_arbiter.sv
// tb/tb_w0rm_sync_arbiter.sv - vector-table bench for w0rm_sync_arbiter (BURST_LEN=3)
// Expectations follow W0RM_SYNC_ARB_BURST_EN when it is defined.
module tb_w0rm_sync_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  input_valid = '0;
  logic [3:0]  input_ready;
  logic [31:0] input_data = '0;
  logic        output_valid;
  logic        output_ready = 1'b0;
  logic [7:0]  output_data;
  logic [1:0]  output_source;

  int checks = 0;
  int errors = 0;

  w0rm_sync_arbiter #(.DATA_WIDTH(8), .NUM_INPUTS(4), .BURST_LEN(3)) dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
    .output_valid(output_valid), .output_ready(output_ready),
    .output_data(output_data), .output_source(output_source)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        oready;
    logic [3:0]  exp_ready;
    logic        exp_ovalid;
    logic [7:0]  exp_data;
    logic [1:0]  exp_src;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic r,
                              logic [3:0] er, logic eov, logic [7:0] ed, logic [1:0] es);
    vec_t t;
    t.valid = v; t.data = d; t.oready = r;
    t.exp_ready = er; t.exp_ovalid = eov; t.exp_data = ed; t.exp_src = es;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int rot_src[6];
  int two_src[7];

  initial begin
`ifdef W0RM_SYNC_ARB_BURST_EN
    rot_src = '{0, 0, 0, 1, 1, 1};
    two_src = '{0, 0, 0, 1, 1, 1, 0};
`else
    rot_src = '{0, 1, 2, 3, 0, 1};
    two_src = '{0, 1, 0, 1, 0, 1, 0};
`endif
    // rotation, all four requesting
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(4'hF, 32'h13121110, 1'b1, 4'(1 << rot_src[k]), 1'b1,
                        8'(8'h10 + rot_src[k]), 2'(rot_src[k])));
    // backpressure on requester 2, then same-cycle restart and drain
    vecs.push_back(mk(4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(4'b0100, 32'h00A50000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2));
    vecs.push_back(mk(4'b0100, 32'h005A0000, 1'b1, 4'b0100, 1'b1, 8'h5A, 2'd2));
    vecs.push_back(mk(4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd2));
    // single requester 3 streaming 1..8
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(4'b1000, {8'(k), 24'h0}, 1'b1, 4'b1000, 1'b1, 8'(k), 2'd3));
    vecs.push_back(mk(4'b0000, 32'h0, 1'b0, 4'b0000, 1'b1, 8'h08, 2'd3));
    vecs.push_back(mk(4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 8'h08, 2'd3));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ovalid", 32'(output_valid), 32'd0);
    check("reset odata", 32'(output_data), 32'd0);
    check("reset osrc", 32'(output_source), 32'd0);
    input_valid = 4'hF;
    #1 check("reset ready", 32'(input_ready), 32'd0);
    input_valid = '0;
    reset = 1'b0;

    foreach (vecs[i]) begin
      input_valid  = vecs[i].valid;
      input_data   = vecs[i].data;
      output_ready = vecs[i].oready;
      #1 check($sformatf("v%0d ready", i), 32'(input_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check($sformatf("v%0d ovalid", i), 32'(output_valid), 32'(vecs[i].exp_ovalid));
      check($sformatf("v%0d odata", i), 32'(output_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d osrc", i), 32'(output_source), 32'(vecs[i].exp_src));
      @(negedge clk);
    end

    // asynchronous reset while a word is held
    input_valid  = 4'hF;
    input_data   = 32'h13121110;
    output_ready = 1'b0;
    @(posedge clk); #1;
    check("pre-reset ovalid", 32'(output_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async ovalid", 32'(output_valid), 32'd0);
    check("async odata", 32'(output_data), 32'd0);
    check("async osrc", 32'(output_source), 32'd0);
    check("async ready", 32'(input_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    output_ready = 1'b1;
    #1 check("post-reset ready", 32'(input_ready), 32'b0001);
    @(posedge clk); #1;
    check("post-reset odata", 32'(output_data), 32'h10);
    check("post-reset osrc", 32'(output_source), 32'd0);

    // two requesters always valid: burst vs plain rotation
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    input_valid = 4'b0011;
    input_data  = 32'h00001110;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      check($sformatf("two[%0d] osrc", k), 32'(output_source), 32'(two_src[k]));
      check($sformatf("two[%0d] odata", k), 32'(output_data), 32'(8'h10 + two_src[k]));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
